shared_slow_memory: RTL and testbench

Parametrised multi-channel successor to the single-channel slow memory model. One line-organised backing array is shared by NUM_CH cache channels (I-cache, D-cache, optional L2) through a round-robin arbiter, and each access has a fixed programmable latency. It sits between the CHIP cache ports and the testbench and replaces one slow memory instance per cache. It serves simulation and FPGA prototyping.

---
 rtl/slow_mem_pkg.sv | 18 +
 rtl/shared_slow_memory_rr_arbiter.sv | 51 +++++
 rtl/shared_slow_memory.sv | 161 ++++++++++++++++
 tb/tb_shared_slow_memory.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_mem_pkg.sv
// Shared definitions for the multi-channel slow memory model: FSM state,
// statistics width and the channel-index width helper.
package slow_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STAT_W = 16;
  localparam int MAX_CH = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_slow_memory_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational grant/valid.
// The pointer advances to grant+1 only when the owner strobes update.
module rr_arbiter
  import slow_mem_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           req,
  input  logic                        update,
  output logic [idx_w(NUM_CH)-1:0]    grant,
  output logic                        valid
);

  localparam int IDX_W = idx_w(NUM_CH);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down so the nearest requester at or after
  // the pointer is the last (and therefore winning) assignment.
  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && valid) begin
      ptr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_slow_memory.sv
// Line-organised memory shared by NUM_CH channels with fixed access latency.
// Optional per-channel statistics counters are built under SLOWMEM_STATS_EN.
module shared_slow_memory
  import slow_mem_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          mem_read,
  input  logic [NUM_CH-1:0]          mem_write,
  input  logic [NUM_CH*ADDR_W-1:0]   mem_addr,
  input  logic [NUM_CH*LINE_W-1:0]   mem_wdata,
  output logic [NUM_CH*LINE_W-1:0]   mem_rdata,
  output logic [NUM_CH-1:0]          mem_ready,
  output logic [NUM_CH-1:0]          err_both,
  output logic [NUM_CH*STAT_W-1:0]   stat_done,
  output logic [NUM_CH*STAT_W-1:0]   stat_stall,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = idx_w(NUM_CH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  // Contents survive rst; the array is intentionally never cleared.
  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [IDX_W-1:0]         grant_q;
  logic [DEPTH_LOG2-1:0]    line_q;
  logic [LINE_W-1:0]        wdata_q;
  logic                     is_write_q;
  logic [NUM_CH-1:0]        ready_q;
  logic [NUM_CH*LINE_W-1:0] rdata_q;
  logic [NUM_CH-1:0]        err_q;

  logic [NUM_CH-1:0] req;
  logic [IDX_W-1:0]  arb_grant;
  logic              arb_valid;
  logic              arb_update;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign req        = mem_read | mem_write;
  assign arb_update = (state_q == IDLE) && arb_valid;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_addr  = mem_addr[int'(arb_grant)*ADDR_W +: ADDR_W];
    sel_wdata = mem_wdata[int'(arb_grant)*LINE_W +: LINE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= '0;
      line_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      ready_q    <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_W'(LATENCY - 2);
            grant_q    <= arb_grant;
            line_q     <= sel_addr[DEPTH_LOG2-1:0];
            wdata_q    <= sel_wdata;
            // Read+write together is serviced as a write and flagged.
            is_write_q <= mem_write[arb_grant];
            if (mem_read[arb_grant] && mem_write[arb_grant]) begin
              err_q[arb_grant] <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q          <= DONE;
            ready_q[grant_q] <= 1'b1;
            if (!is_write_q) begin
              rdata_q[int'(grant_q)*LINE_W +: LINE_W] <= mem[line_q];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == DONE) && is_write_q) begin
      mem[line_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign err_both  = err_q;
  assign dbg_state = state_q;

`ifdef SLOWMEM_STATS_EN
  logic [NUM_CH*STAT_W-1:0] done_q, done_d, stall_q, stall_d;
  logic [IDX_W-1:0]         act_grant;
  logic                     act_valid;

  // In IDLE the arbiter's pick counts as the active grant for that cycle.
  always_comb begin
    act_grant = (state_q == IDLE) ? arb_grant : grant_q;
    act_valid = (state_q == IDLE) ? arb_valid : 1'b1;
    done_d    = done_q;
    stall_d   = stall_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ready_q[c] && (done_q[c*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
        done_d[c*STAT_W +: STAT_W] = done_q[c*STAT_W +: STAT_W] + 1'b1;
      end
      if (req[c] && !(act_valid && (int'(act_grant) == c)) &&
          (stall_q[c*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
        stall_d[c*STAT_W +: STAT_W] = stall_q[c*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      stall_q <= '0;
    end else begin
      done_q  <= done_d;
      stall_q <= stall_d;
    end
  end

  assign stat_done  = done_q;
  assign stat_stall = stall_q;
`else
  assign stat_done  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_shared_slow_memory.sv
// Bench for shared_slow_memory (NUM_CH=2, LATENCY=4): table of single
// transactions, then arbitration, read+write, reset-abort and random sequences.
module tb_shared_slow_memory;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int DEPTH_LOG2 = 12;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rd_v = '0;
  logic [1:0] wr_v = '0;
  logic [ADDR_W-1:0] addr_v [2];
  logic [LINE_W-1:0] wdata_v [2];

  logic [NUM_CH*ADDR_W-1:0] mem_addr;
  logic [NUM_CH*LINE_W-1:0] mem_wdata;
  logic [NUM_CH*LINE_W-1:0] mem_rdata;
  logic [NUM_CH-1:0] mem_ready;
  logic [NUM_CH-1:0] err_both;
  logic [NUM_CH*16-1:0] stat_done;
  logic [NUM_CH*16-1:0] stat_stall;
  logic [1:0] dbg_state;

  assign mem_addr  = {addr_v[1], addr_v[0]};
  assign mem_wdata = {wdata_v[1], wdata_v[0]};

  shared_slow_memory #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W),
    .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(rd_v), .mem_write(wr_v),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err_both(err_both), .stat_done(stat_done),
    .stat_stall(stat_stall), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard and reference model
  logic [LINE_W-1:0] exp_q0 [$];
  logic [LINE_W-1:0] exp_q1 [$];
  logic [LINE_W-1:0] exp_rd [2];
  logic [LINE_W-1:0] model_mem [logic [DEPTH_LOG2-1:0]];
  logic [1:0] err_model = '0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (mem_ready[c] === 1'b1) begin
        if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready ch%0d", c);
        end else begin
          chk($sformatf("rdata_ch%0d", c), mem_rdata[c*LINE_W +: LINE_W],
              (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front());
        end
      end
    end
  end

  // driver: call aligned #1 after a rising edge; returns likewise
  task automatic do_txn(input int ch, input logic r, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                        output int lat);
    logic [DEPTH_LOG2-1:0] line;
    line = a[DEPTH_LOG2-1:0];
    rd_v[ch] = r;
    wr_v[ch] = w;
    addr_v[ch] = a;
    wdata_v[ch] = d;
    if (w) model_mem[line] = d;
    else exp_rd[ch] = model_mem[line];
    if (r && w) err_model[ch] = 1'b1;
    if (ch == 0) exp_q0.push_back(exp_rd[0]);
    else exp_q1.push_back(exp_rd[1]);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mem_ready[ch] === 1'b1) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_v[ch] = 1'b0;
    wr_v[ch] = 1'b0;
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout ch%0d: got no ready expected ready", ch);
      if (ch == 0) void'(exp_q0.pop_back());
      else void'(exp_q1.pop_back());
    end
    chk("err_both", LINE_W'(err_both), LINE_W'(err_model));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    rd_v = '0;
    wr_v = '0;
    #1;
    chk("rst_ready", LINE_W'(mem_ready), '0);
    chk("rst_rdata", mem_rdata[LINE_W-1:0] | mem_rdata[2*LINE_W-1:LINE_W], '0);
    chk("rst_err", LINE_W'(err_both), '0);
    chk("rst_state", LINE_W'(dbg_state), '0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    err_model = '0;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int ch;
    logic rd;
    logic wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, l0a, l0b, l1;
    logic [LINE_W-1:0] line_a5;
    logic [ADDR_W-1:0] ra;
    logic [LINE_W-1:0] rdat;
    int wch;
    line_a5 = {16{8'hA5}};
    addr_v[0] = '0; addr_v[1] = '0;
    wdata_v[0] = '0; wdata_v[1] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    vecs[0] = '{1, 1'b0, 1'b1, 28'd5, line_a5, 4};
    vecs[1] = '{0, 1'b1, 1'b0, 28'd5, '0, 4};
    vecs[2] = '{1, 1'b0, 1'b1, 28'd7, 128'h1234, 4};
    vecs[3] = '{0, 1'b1, 1'b0, 28'd7, '0, 4};
    vecs[4] = '{1, 1'b1, 1'b0, 28'd7 + 28'd4096, '0, 4};
    vecs[5] = '{0, 1'b0, 1'b1, 28'd1, {4{32'h1111_2222}}, 4};
    vecs[6] = '{1, 1'b0, 1'b1, 28'd2, {4{32'h3333_4444}}, 4};
    vecs[7] = '{0, 1'b0, 1'b1, 28'hFFF, {4{32'hDEAD_BEEF}}, 4};
    vecs[8] = '{1, 1'b1, 1'b0, 28'hABCDFFF, '0, 4};
    vecs[9] = '{0, 1'b1, 1'b0, 28'h0001001, '0, 4};

    #2;
    chk("por_ready", LINE_W'(mem_ready), '0);
    chk("por_rdata", mem_rdata[LINE_W-1:0] | mem_rdata[2*LINE_W-1:LINE_W], '0);
    chk("por_stats", LINE_W'({stat_done, stat_stall}), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].ch, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("latency_vec%0d", i), LINE_W'(lat), LINE_W'(vecs[i].lat));
    end

    // line 5 after reset: only ch0 completes, ch1 rdata stays cleared
    do_reset();
    do_txn(0, 1'b1, 1'b0, 28'd5, '0, lat);
    chk("preload_lat", LINE_W'(lat), LINE_W'(4));
    chk("preload_rdata0", mem_rdata[LINE_W-1:0], line_a5);
    chk("preload_rdata1", mem_rdata[2*LINE_W-1:LINE_W], '0);

    // simultaneous requests, then ch0 reissues and loses to ch1
    do_reset();
    fork
      begin
        do_txn(0, 1'b1, 1'b0, 28'd1, '0, l0a);
        chk("both_lat0", LINE_W'(l0a), LINE_W'(4));
        do_txn(0, 1'b1, 1'b0, 28'd1, '0, l0b);
        chk("rr_lat0", LINE_W'(l0b), LINE_W'(9));
      end
      begin
        do_txn(1, 1'b1, 1'b0, 28'd2, '0, l1);
        chk("both_lat1", LINE_W'(l1), LINE_W'(9));
`ifdef SLOWMEM_STATS_EN
        chk("stat_done", LINE_W'(stat_done), LINE_W'({16'd1, 16'd1}));
        chk("stat_stall1", LINE_W'(stat_stall[31:16]), LINE_W'(5));
`else
        chk("stat_done", LINE_W'(stat_done), '0);
        chk("stat_stall", LINE_W'(stat_stall), '0);
`endif
      end
    join

    // read+write together on ch0 is a write and sets a sticky flag
    do_txn(0, 1'b1, 1'b1, 28'd20, {4{32'h0BAD_F00D}}, lat);
    chk("both_rw_lat", LINE_W'(lat), LINE_W'(4));
    chk("both_rw_err", LINE_W'(err_both), LINE_W'(2'b01));
    do_txn(1, 1'b1, 1'b0, 28'd20, '0, lat);
    chk("both_rw_persist", LINE_W'(err_both), LINE_W'(2'b01));

    // reset in cycle 2 of a write aborts it
    wr_v[0] = 1'b1;
    addr_v[0] = 28'd5;
    wdata_v[0] = {4{32'hCAFE_0000}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    do_txn(0, 1'b1, 1'b0, 28'd5, '0, lat);
    chk("abort_next_lat", LINE_W'(lat), LINE_W'(LATENCY));

    for (int i = 0; i < 6; i++) begin
      wch = $urandom_range(0, 1);
      ra = {16'($urandom_range(0, 65535)), 12'($urandom_range(0, 4095))};
      rdat = {$urandom, $urandom, $urandom, $urandom};
      do_txn(wch, 1'b0, 1'b1, ra, rdat, lat);
      ra = {16'($urandom_range(0, 65535)), ra[11:0]};
      do_txn(1 - wch, 1'b1, 1'b0, ra, '0, lat);
      chk("rand_lat", LINE_W'(lat), LINE_W'(4));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", LINE_W'(exp_q0.size() + exp_q1.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
